dice_reader: RTL

- Consumer side of the electronic dice: watches `button` and the dice `throw` bus, and captures the settled face after each release.
- Validates the face, drives a 7-LED pip pattern, and keeps a running score, a roll count and double-roll detection.
- Sits between the dice block and the board LEDs/score display.

---
 rtl/dice_reader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/dice_reader.sv
// dice_reader: captures the settled dice face after each button release,
// validates it, and drives the LED pip pattern, a saturating score,
// a saturating roll count and double-roll detection.
module dice_reader #(
    parameter int SETTLE_CYCLES = 2,
    parameter int SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [2:0]         throw,
    output logic               valid,
    output logic               err,
    output logic [2:0]         face,
    output logic [6:0]         pips,
    output logic               double,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         roll_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROLLING = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [3:0] next_cnt;
    logic       have_prev;
    logic       legal;

    // Score accumulate that sticks at the all-ones maximum instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] acc,
                                                     input logic [2:0]         add);
        logic [SCORE_W+3:0] sum;
        sum = {4'b0000, acc} + {{(SCORE_W + 1){1'b0}}, add};
        if (sum > {4'b0000, {SCORE_W{1'b1}}})
            return {SCORE_W{1'b1}};
        return sum[SCORE_W-1:0];
    endfunction

    // Roll counter increment that sticks at 255.
    function automatic logic [7:0] sat_count(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Face to LED pattern: bit0 TL, bit1 TR, bit2 ML, bit3 C, bit4 MR, bit5 BL, bit6 BR.
    function automatic logic [6:0] pip_map(input logic [2:0] f);
        case (f)
            3'd1:    return 7'h08;
            3'd2:    return 7'h41;
            3'd3:    return 7'h49;
            3'd4:    return 7'h63;
            3'd5:    return 7'h6B;
            3'd6:    return 7'h77;
            default: return 7'h00;
        endcase
    endfunction

    assign legal = (throw != 3'd0) && (throw != 3'd7);

    // State and settle counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state logic: wait for press, wait for release, settle, then capture.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (button)
                    next_state = ROLLING;
            end
            ROLLING: begin
                if (!button) begin
                    next_state = SETTLE;
                    next_cnt   = 4'd0;
                end
            end
            SETTLE: begin
                if (button) begin
                    // Re-press aborts the roll before anything is sampled.
                    next_state = ROLLING;
                    next_cnt   = 4'd0;
                end else if (cnt == LAST_CNT) begin
                    next_state = CAPTURE;
                end else begin
                    next_cnt = cnt + 4'd1;
                end
            end
            CAPTURE: begin
                next_state = button ? ROLLING : IDLE;
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

    // Capture registers: pulses default low, face/score/count update only on a legal sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid      <= 1'b0;
            err        <= 1'b0;
            double     <= 1'b0;
            face       <= 3'd0;
            pips       <= 7'd0;
            score      <= '0;
            roll_count <= 8'd0;
            have_prev  <= 1'b0;
        end else begin
            valid  <= 1'b0;
            err    <= 1'b0;
            double <= 1'b0;
            if (state == CAPTURE) begin
                if (legal) begin
                    face       <= throw;
                    pips       <= pip_map(throw);
                    valid      <= 1'b1;
                    score      <= sat_score(score, throw);
                    roll_count <= sat_count(roll_count);
                    double     <= have_prev && (throw == face);
                    have_prev  <= 1'b1;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule
